btn_event_arbiter: RTL and testbench

Collects one-cycle press pulses from up to N_BTN per-button pulse generators and latches each one as a pending event. It serializes the pending events, round-robin, onto a single valid/ready event port that a downstream consumer (menu/control FSM) drains. It sits between the per-button pulse generators and the consumer, so that no press is lost while the consumer is busy. It flags per-button overruns when a button fires again before its previous event has been accepted.

---
 rtl/btn_arb_pkg.sv | 13 +
 rtl/btn_event_arbiter_rr_pick.sv | 27 ++
 rtl/btn_event_arbiter.sv | 128 ++++++++++++
 tb/tb_btn_event_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/btn_arb_pkg.sv
// Shared types and limits for the button event arbiter.
package btn_arb_pkg;

   // Largest number of button channels the arbiter is meant to serve.
   localparam int N_BTN_MAX = 16;

   // IDLE: nothing offered. OFFER: evt_id_o is valid and held until accepted.
   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } arb_state_t;

endpackage : btn_arb_pkg

// File: rtl/btn_event_arbiter_rr_pick.sv
// Rotating-priority finder: returns the first set request at or above
// 'start_i', wrapping from N_BTN-1 back to 0. Purely combinational.
module rr_pick #(
   parameter int N_BTN = 4,
   localparam int ID_W = $clog2(N_BTN)
) (
   input  logic [N_BTN-1:0] req_i,
   input  logic [ID_W-1:0]  start_i,
   output logic             any_o,
   output logic [ID_W-1:0]  idx_o
);

   // Walk the channels in rotated order and keep the first hit.
   always_comb begin
      any_o = 1'b0;
      idx_o = '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
         int unsigned pos;
         pos = (int'(start_i) + i) % N_BTN;
         if (!any_o && req_i[pos]) begin
            any_o = 1'b1;
            idx_o = ID_W'(pos);
         end
      end
   end

endmodule : rr_pick

// File: rtl/btn_event_arbiter.sv
// Latches per-button press pulses as pending events and serializes them,
// round-robin, onto one valid/ready event port. Repeated presses on a
// channel that is still pending or on offer are dropped and flagged.
//
// Handshake: an event transfers on every rising edge where evt_valid_o and
// evt_ready_i are both high; evt_id_o is held stable while evt_valid_o is
// high and not yet accepted.
module btn_event_arbiter
   import btn_arb_pkg::*;
#(
   parameter int N_BTN = 4,
   localparam int ID_W = $clog2(N_BTN)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [N_BTN-1:0] pulse_i,
   output logic             evt_valid_o,
   output logic [ID_W-1:0]  evt_id_o,
   input  logic             evt_ready_i,
   output logic [N_BTN-1:0] overrun_o,
   input  logic             clr_overrun_i
);

   arb_state_t       state_q, state_d;
   logic [N_BTN-1:0] pending_q, pending_d;
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]  id_q, id_d;
   logic [N_BTN-1:0] overrun_q, overrun_d;

   logic             hs;
   logic [ID_W-1:0]  ptr_next;
   logic [N_BTN-1:0] id_oh;
   logic [N_BTN-1:0] pick_oh;
   logic [N_BTN-1:0] clr_mask;
   logic [N_BTN-1:0] hold_mask;
   logic [N_BTN-1:0] cand;
   logic [N_BTN-1:0] ovr_set;
   logic [ID_W-1:0]  pick_start;
   logic             pick_any;
   logic [ID_W-1:0]  pick_idx;

   assign hs = (state_q == OFFER) && evt_ready_i;

   // Pointer just past the offered channel, with wrap at N_BTN-1.
   always_comb begin
      if (id_q == ID_W'(N_BTN - 1)) ptr_next = '0;
      else                          ptr_next = id_q + ID_W'(1);
   end

   // One-hot decodes of the offered id and of the arbitration winner.
   always_comb begin
      id_oh             = '0;
      id_oh[id_q]       = 1'b1;
      pick_oh           = '0;
      pick_oh[pick_idx] = 1'b1;
   end

   // Candidate set: the accepted channel leaves, a channel still on offer
   // cannot re-enter, and a pulse on a busy channel becomes an overrun.
   always_comb begin
      clr_mask  = hs ? id_oh : '0;
      hold_mask = ((state_q == OFFER) && !evt_ready_i) ? id_oh : '0;
      cand      = (pending_q & ~clr_mask) | (pulse_i & ~hold_mask);
      ovr_set   = pulse_i & (pending_q | hold_mask);
      overrun_d = (overrun_q & ~{N_BTN{clr_overrun_i}}) | ovr_set;
   end

   // After an accept, search resumes just past the accepted channel.
   assign pick_start = hs ? ptr_next : rr_ptr_q;

   rr_pick #(.N_BTN(N_BTN)) u_pick (
      .req_i   (cand),
      .start_i (pick_start),
      .any_o   (pick_any),
      .idx_o   (pick_idx)
   );

   // Next-state logic: load a winner when idle or right after an accept.
   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      rr_ptr_d  = rr_ptr_q;
      pending_d = cand;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d   = OFFER;
               id_d      = pick_idx;
               pending_d = cand & ~pick_oh;
            end
         end
         OFFER: begin
            if (hs) begin
               rr_ptr_d = ptr_next;
               if (pick_any) begin
                  id_d      = pick_idx;
                  pending_d = cand & ~pick_oh;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset discards the offer and all pending events.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         pending_q <= '0;
         rr_ptr_q  <= '0;
         id_q      <= '0;
         overrun_q <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         rr_ptr_q  <= rr_ptr_d;
         id_q      <= id_d;
         overrun_q <= overrun_d;
      end
   end

   assign evt_valid_o = (state_q == OFFER);
   assign evt_id_o    = id_q;
   assign overrun_o   = overrun_q;

endmodule : btn_event_arbiter

// File: tb/tb_btn_event_arbiter.sv
// Directed bench for btn_event_arbiter (N_BTN = 4).
module tb_btn_event_arbiter;

   localparam int N_BTN = 4;
   localparam int ID_W  = 2;

   logic             clk;
   logic             rst_i;
   logic [N_BTN-1:0] pulse_i;
   logic             evt_valid_o;
   logic [ID_W-1:0]  evt_id_o;
   logic             evt_ready_i;
   logic [N_BTN-1:0] overrun_o;
   logic             clr_overrun_i;

   int n_chk;
   int n_pass;

   logic [ID_W-1:0] exp_q[$];
   logic [ID_W-1:0] got_q[$];

   btn_event_arbiter #(.N_BTN(N_BTN)) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .pulse_i       (pulse_i),
      .evt_valid_o   (evt_valid_o),
      .evt_id_o      (evt_id_o),
      .evt_ready_i   (evt_ready_i),
      .overrun_o     (overrun_o),
      .clr_overrun_i (clr_overrun_i)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Event monitor: record every accepted id
   always @(posedge clk) begin
      if (!rst_i && evt_valid_o && evt_ready_i) got_q.push_back(evt_id_o);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Advance one edge; inputs are changed and outputs sampled 1ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_i         = 1'b1;
      pulse_i       = '0;
      evt_ready_i   = 1'b0;
      clr_overrun_i = 1'b0;
      tick();
      rst_i = 1'b0;
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic check_events(input string tag);
      int n;
      check({tag, "_count"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_id%0d", tag, i), got_q[i], exp_q[i]);
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;

      // Reset with all buttons pulsing: nothing must come out
      rst_i = 1'b1; pulse_i = 4'b1111; evt_ready_i = 1'b1; clr_overrun_i = 1'b0;
      tick();
      tick();
      rst_i = 1'b0; pulse_i = 4'b0000;
      got_q.delete();
      check("rst_valid", evt_valid_o, 1'b0);
      check("rst_id", evt_id_o, 2'd0);
      check("rst_ovr", overrun_o, 4'b0000);
      for (int i = 0; i < 4; i++) tick();
      check("rst_valid_late", evt_valid_o, 1'b0);
      check_events("rst_evts");

      // Single press on ch2, one-cycle offer
      do_reset();
      evt_ready_i = 1'b1;
      pulse_i = 4'b0100;
      tick();
      pulse_i = 4'b0000;
      check("single_valid", evt_valid_o, 1'b1);
      check("single_id", evt_id_o, 2'd2);
      tick();
      check("single_idle", evt_valid_o, 1'b0);
      tick();
      exp_q = '{2'd2};
      check_events("single_evts");

      // Simultaneous presses 1011: ids 0,1,3 back to back
      do_reset();
      evt_ready_i = 1'b1;
      pulse_i = 4'b1011;
      tick();
      pulse_i = 4'b0000;
      check("sim_id0", evt_id_o, 2'd0);
      check("sim_v0", evt_valid_o, 1'b1);
      tick();
      check("sim_id1", evt_id_o, 2'd1);
      check("sim_v1", evt_valid_o, 1'b1);
      tick();
      check("sim_id2", evt_id_o, 2'd3);
      check("sim_v2", evt_valid_o, 1'b1);
      tick();
      check("sim_end", evt_valid_o, 1'b0);
      exp_q = '{2'd0, 2'd1, 2'd3};
      check_events("sim_evts");

      // Backpressure with a duplicate press on ch1
      do_reset();
      evt_ready_i = 1'b0;
      pulse_i = 4'b0010;
      tick();
      pulse_i = 4'b0000;
      for (int c = 1; c <= 5; c++) begin
         check($sformatf("bp_valid_c%0d", c), evt_valid_o, 1'b1);
         check($sformatf("bp_id_c%0d", c), evt_id_o, 2'd1);
         pulse_i = (c == 3) ? 4'b0010 : 4'b0000;
         tick();
      end
      pulse_i = 4'b0000;
      check("bp_ovr", overrun_o, 4'b0010);
      evt_ready_i = 1'b1;
      tick();
      check("bp_after_hs", evt_valid_o, 1'b0);
      tick();
      tick();
      check("bp_no_dup", evt_valid_o, 1'b0);
      check("bp_ovr_sticky", overrun_o, 4'b0010);
      exp_q = '{2'd1};
      check_events("bp_evts");
      clr_overrun_i = 1'b1;
      tick();
      clr_overrun_i = 1'b0;
      check("bp_ovr_clr", overrun_o, 4'b0000);

      // Fairness: ch0 every cycle, ch3 once
      do_reset();
      evt_ready_i = 1'b1;
      for (int c = 0; c < 6; c++) begin
         pulse_i = (c == 0) ? 4'b1001 : 4'b0001;
         tick();
      end
      pulse_i = 4'b0000;
      tick();
      tick();
      check("fair_idle", evt_valid_o, 1'b0);
      check("fair_ovr3", overrun_o[3], 1'b0);
      check("fair_ovr", overrun_o, 4'b0001);
      exp_q = '{2'd0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
      check_events("fair_evts");

      // Reset while offering ch2 with ch0 pending
      do_reset();
      evt_ready_i = 1'b0;
      pulse_i = 4'b0100;
      tick();
      pulse_i = 4'b0001;
      tick();
      pulse_i = 4'b0000;
      check("mid_valid", evt_valid_o, 1'b1);
      check("mid_id", evt_id_o, 2'd2);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check("mid_rst_valid", evt_valid_o, 1'b0);
      check("mid_rst_id", evt_id_o, 2'd0);
      evt_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      check("mid_quiet", evt_valid_o, 1'b0);
      exp_q.delete();
      check_events("mid_evts");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_btn_event_arbiter
